// File: rtl/barker_peak_sync_if.sv
// Chip-rate correlation input and per-symbol decision/lock outputs of barker_peak_sync.
interface barker_peak_sync_if #(
  parameter int SUMLEN = 15
);
  logic signed [SUMLEN-1:0] CorrIn;
  logic                     CorrValid;
  logic        [SUMLEN-1:0] Threshold;
  logic                     BitOut;
  logic                     BitValid;
  logic                     Locked;
  logic        [2:0]        PeakPhase;
  logic        [SUMLEN-1:0] PeakMag;

  modport master (
    output CorrIn, CorrValid, Threshold,
    input  BitOut, BitValid, Locked, PeakPhase, PeakMag
  );

  modport slave (
    input  CorrIn, CorrValid, Threshold,
    output BitOut, BitValid, Locked, PeakPhase, PeakMag
  );
endinterface

// File: rtl/barker_peak_sync.sv
// Barker correlation peak search/verify/lock with one hard-decision bit per locked symbol.
// Build option: define DIFF_DECODE_EN for DBPSK differential decision instead of absolute sign.
//
// state     | meaning
// ST_SEARCH | scan aligned 7-chip windows for the largest magnitude
// ST_VERIFY | confirm the candidate phase with consecutive hits
// ST_LOCK   | emit one bit per symbol, drop after MISS_MAX consecutive misses
module barker_peak_sync #(
  parameter int sumlen      = 15,
  parameter int VERIFY_HITS = 3,
  parameter int MISS_MAX    = 4
) (
  input logic               clk,
  input logic               reset,
  barker_peak_sync_if.slave bus
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  localparam logic [2:0] LP_LAST_PHASE = 3'd6;
  localparam logic [2:0] LP_VHITS      = 3'(VERIFY_HITS);
  localparam logic [2:0] LP_MMAX       = 3'(MISS_MAX);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_phase;
  logic [2:0]        r_peak_phase;
  logic [2:0]        r_max_phase;
  logic [2:0]        r_hit_cnt;
  logic [2:0]        r_miss_cnt;
  logic [sumlen-1:0] r_max;
  logic [sumlen-1:0] r_peak_mag;
  logic              r_max_sign;
  logic              r_sign;
  logic              r_armed;
  logic              r_bit_out;
  logic              r_bit_valid;
  logic              r_locked;

  logic [sumlen-1:0] w_corr_u;
  logic [sumlen-1:0] w_mag;
  logic [sumlen-1:0] w_win_mag;
  logic [2:0]        w_win_phase;
  logic [2:0]        w_hit_inc;
  logic [2:0]        w_miss_inc;
  logic              w_sign;
  logic              w_hit;
  logic              w_at_peak;
  logic              w_in_win;
  logic              w_max_upd;
  logic              w_win_end;
  logic              w_win_found;
  logic              w_win_sign;
  logic              w_last_miss;
  logic              w_issue_bit;
  logic              w_decision;

  // Two's-complement magnitude; the most negative input maps to 2^(sumlen-1) unsaturated.
  assign w_corr_u = bus.CorrIn;
  assign w_sign   = bus.CorrIn[sumlen-1];
  assign w_mag    = w_sign ? (~w_corr_u + 1'b1) : w_corr_u;
  assign w_hit    = (w_mag >= bus.Threshold);

  assign w_at_peak = bus.CorrValid && (r_phase == r_peak_phase);
  assign w_in_win  = bus.CorrValid && (r_armed || (r_phase == 3'd0));

  // Strictly greater keeps the earliest phase on ties.
  assign w_max_upd   = (w_mag > r_max);
  assign w_win_mag   = w_max_upd ? w_mag   : r_max;
  assign w_win_phase = w_max_upd ? r_phase : r_max_phase;
  assign w_win_sign  = w_max_upd ? w_sign  : r_max_sign;
  assign w_win_end   = w_in_win && (r_phase == LP_LAST_PHASE);
  assign w_win_found = w_win_end && (w_win_mag >= bus.Threshold);

  assign w_hit_inc   = r_hit_cnt + 3'd1;
  assign w_miss_inc  = r_miss_cnt + 3'd1;
  assign w_last_miss = w_at_peak && !w_hit && (w_miss_inc == LP_MMAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_SEARCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SEARCH: begin
        if (w_win_found) begin
          w_state_nxt = (LP_VHITS == 3'd1) ? ST_LOCK : ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (w_at_peak) begin
          if (!w_hit) begin
            w_state_nxt = ST_SEARCH;
          end else if (w_hit_inc == LP_VHITS) begin
            w_state_nxt = ST_LOCK;
          end
        end
      end
      ST_LOCK: begin
        if (w_last_miss) begin
          w_state_nxt = ST_SEARCH;
        end
      end
      default: w_state_nxt = ST_SEARCH;
    endcase
  end

  always_comb begin
    w_issue_bit = (r_state == ST_LOCK) && w_at_peak && !w_last_miss;
`ifdef DIFF_DECODE_EN
    w_decision  = ~(w_sign ^ r_sign);
`else
    w_decision  = ~w_sign;
`endif
  end

`ifndef DIFF_DECODE_EN
  // Sign history is still tracked so both decode modes share one datapath.
  logic w_unused_sign;
  assign w_unused_sign = r_sign;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase      <= '0;
      r_peak_phase <= '0;
      r_max_phase  <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_max        <= '0;
      r_peak_mag   <= '0;
      r_max_sign   <= 1'b0;
      r_sign       <= 1'b0;
      r_armed      <= 1'b0;
      r_bit_out    <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_bit_valid <= 1'b0;
      r_locked    <= (w_state_nxt == ST_LOCK);

      if (bus.CorrValid) begin
        r_phase <= (r_phase == LP_LAST_PHASE) ? 3'd0 : r_phase + 3'd1;
      end

      if (w_issue_bit) begin
        r_bit_valid <= 1'b1;
        r_bit_out   <= w_decision;
      end

      case (r_state)
        ST_SEARCH: begin
          if (w_in_win) begin
            r_armed <= 1'b1;
            if (w_win_end) begin
              r_max       <= '0;
              r_max_phase <= '0;
              r_max_sign  <= 1'b0;
              if (w_win_found) begin
                // Re-entering SEARCH later must wait for a fresh phase-0 window.
                r_armed      <= 1'b0;
                r_peak_phase <= w_win_phase;
                r_peak_mag   <= w_win_mag;
                r_hit_cnt    <= 3'd1;
                r_miss_cnt   <= '0;
                r_sign       <= w_win_sign;
              end
            end else if (w_max_upd) begin
              r_max       <= w_mag;
              r_max_phase <= r_phase;
              r_max_sign  <= w_sign;
            end
          end
        end
        ST_VERIFY: begin
          if (w_at_peak) begin
            r_peak_mag <= w_mag;
            if (w_hit) begin
              r_hit_cnt  <= w_hit_inc;
              r_sign     <= w_sign;
              r_miss_cnt <= '0;
            end else begin
              r_hit_cnt <= '0;
            end
          end
        end
        ST_LOCK: begin
          if (w_at_peak) begin
            r_peak_mag <= w_mag;
            r_sign     <= w_sign;
            if (w_hit) begin
              r_miss_cnt <= '0;
            end else if (w_last_miss) begin
              r_miss_cnt <= '0;
              r_hit_cnt  <= '0;
            end else begin
              r_miss_cnt <= w_miss_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.BitOut    = r_bit_out;
  assign bus.BitValid  = r_bit_valid;
  assign bus.Locked    = r_locked;
  assign bus.PeakPhase = r_peak_phase;
  assign bus.PeakMag   = r_peak_mag;

endmodule

// File: tb/tb_barker_peak_sync.sv
// Directed bench for barker_peak_sync: acquisition, bit timing, miss drop, ties, decode and reset.
module tb_barker_peak_sync;

  typedef int sym_t [7];

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [6:0] s_bv;
  logic [6:0] s_bo;
  logic [6:0] s_lk;
  logic [6:0] s_gbv;

  barker_peak_sync_if #(.SUMLEN(15)) bus_if ();

  barker_peak_sync dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chip(input int v);
    bus_if.CorrIn    = 15'(v);
    bus_if.CorrValid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    bus_if.CorrValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus_if.CorrValid = 1'b0;
    bus_if.CorrIn    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input sym_t v, input bit gaps);
    s_bv  = '0;
    s_bo  = '0;
    s_lk  = '0;
    s_gbv = '0;
    for (int k = 0; k < 7; k++) begin
      chip(v[k]);
      s_bv[k] = bus_if.BitValid;
      s_bo[k] = bus_if.BitOut;
      s_lk[k] = bus_if.Locked;
      if (gaps) begin
        idle();
        s_gbv[k] = bus_if.BitValid;
      end
    end
    bus_if.CorrValid = 1'b0;
  endtask

  // Peak at phase 3, alternating +/-50 elsewhere.
  task automatic run_std(input int pk, input bit gaps);
    sym_t v;
    for (int k = 0; k < 7; k++) v[k] = (k == 3) ? pk : ((k % 2 == 1) ? 50 : -50);
    run_vec(v, gaps);
  endtask

  task automatic test_reset();
    bus_if.Threshold = 15'd100;
    do_reset();
    checks++; if (bus_if.BitOut !== 1'b0) begin errors++; $display("FAIL reset_bitout: got %b expected 0", bus_if.BitOut); end
    checks++; if (bus_if.BitValid !== 1'b0) begin errors++; $display("FAIL reset_bitvalid: got %b expected 0", bus_if.BitValid); end
    checks++; if (bus_if.Locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", bus_if.Locked); end
    checks++; if (bus_if.PeakPhase !== 3'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", bus_if.PeakPhase); end
    checks++; if (bus_if.PeakMag !== 15'd0) begin errors++; $display("FAIL reset_mag: got %0d expected 0", bus_if.PeakMag); end
    for (int i = 0; i < 14; i++) begin
      chip(0);
      checks++; if (bus_if.BitValid !== 1'b0 || bus_if.Locked !== 1'b0) begin
        errors++; $display("FAIL zeros_idle chip%0d: got bv=%b lk=%b expected bv=0 lk=0", i, bus_if.BitValid, bus_if.Locked);
      end
    end
    bus_if.CorrValid = 1'b0;
    checks++; if (bus_if.PeakPhase !== 3'd0 || bus_if.PeakMag !== 15'd0 || bus_if.BitOut !== 1'b0) begin
      errors++; $display("FAIL zeros_outputs: got ph=%0d mag=%0d bo=%b expected 0 0 0", bus_if.PeakPhase, bus_if.PeakMag, bus_if.BitOut);
    end
  endtask

  task automatic test_acquire();
    bus_if.Threshold = 15'd500;
    run_std(1000, 1'b0);
    checks++; if (bus_if.Locked !== 1'b0 || bus_if.PeakPhase !== 3'd3 || bus_if.PeakMag !== 15'd1000) begin
      errors++; $display("FAIL acq_candidate: got lk=%b ph=%0d mag=%0d expected 0 3 1000", bus_if.Locked, bus_if.PeakPhase, bus_if.PeakMag);
    end
    run_std(1000, 1'b0);
    checks++; if (s_lk !== 7'b0000000 || s_bv !== 7'b0) begin
      errors++; $display("FAIL acq_verify2: got lk=%b bv=%b expected 0000000 0000000", s_lk, s_bv);
    end
    run_std(1000, 1'b0);
    checks++; if (s_lk !== 7'b1111000 || s_bv !== 7'b0 || bus_if.PeakPhase !== 3'd3) begin
      errors++; $display("FAIL acq_lock: got lk=%b bv=%b ph=%0d expected 1111000 0000000 3", s_lk, s_bv, bus_if.PeakPhase);
    end
    for (int s = 0; s < 3; s++) begin
      run_std(1000, 1'b0);
      checks++; if (s_bv !== 7'b0001000 || s_bo[3] !== 1'b1) begin
        errors++; $display("FAIL acq_bit sym%0d: got bv=%b bo=%b expected bv=0001000 bo=1", s, s_bv, s_bo[3]);
      end
    end
  endtask

  task automatic test_miss_drop();
    for (int m = 0; m < 3; m++) begin
      run_std(200, 1'b0);
      checks++; if (s_bv !== 7'b0001000 || s_bo[3] !== 1'b1 || s_lk !== 7'b1111111) begin
        errors++; $display("FAIL miss_bit%0d: got bv=%b bo=%b lk=%b expected 0001000 1 1111111", m + 1, s_bv, s_bo[3], s_lk);
      end
      checks++; if (bus_if.PeakMag !== 15'd200) begin
        errors++; $display("FAIL miss_mag%0d: got %0d expected 200", m + 1, bus_if.PeakMag);
      end
    end
    run_std(200, 1'b0);
    checks++; if (s_bv !== 7'b0 || s_lk !== 7'b0000111) begin
      errors++; $display("FAIL miss_drop: got bv=%b lk=%b expected 0000000 0000111", s_bv, s_lk);
    end
    run_std(1000, 1'b0);
    checks++; if (s_lk !== 7'b0) begin errors++; $display("FAIL relock_search: got lk=%b expected 0000000", s_lk); end
    run_std(1000, 1'b0);
    checks++; if (s_lk !== 7'b0) begin errors++; $display("FAIL relock_verify: got lk=%b expected 0000000", s_lk); end
    run_std(1000, 1'b0);
    checks++; if (s_lk !== 7'b1111000 || s_bv !== 7'b0) begin
      errors++; $display("FAIL relock_lock: got lk=%b bv=%b expected 1111000 0000000", s_lk, s_bv);
    end
    run_std(1000, 1'b0);
    checks++; if (s_bv !== 7'b0001000 || s_bo[3] !== 1'b1) begin
      errors++; $display("FAIL relock_bit: got bv=%b bo=%b expected 0001000 1", s_bv, s_bo[3]);
    end
  endtask

  task automatic test_tie_negmax();
    sym_t v;
    logic exp_bo;
    do_reset();
    bus_if.Threshold = 15'd500;
    v = '{10, 10, 800, 10, 10, 800, 10};
    run_vec(v, 1'b0);
    checks++; if (bus_if.PeakPhase !== 3'd2 || bus_if.PeakMag !== 15'd800) begin
      errors++; $display("FAIL tie_phase: got ph=%0d mag=%0d expected 2 800", bus_if.PeakPhase, bus_if.PeakMag);
    end
    v = '{10, 10, -16384, 10, 10, 10, 10};
    run_vec(v, 1'b0);
    checks++; if (bus_if.PeakMag !== 15'd16384 || bus_if.Locked !== 1'b0) begin
      errors++; $display("FAIL negmax_mag: got mag=%0d lk=%b expected 16384 0", bus_if.PeakMag, bus_if.Locked);
    end
    run_vec(v, 1'b0);
    checks++; if (s_lk !== 7'b1111100) begin errors++; $display("FAIL negmax_lock: got lk=%b expected 1111100", s_lk); end
`ifdef DIFF_DECODE_EN
    exp_bo = 1'b1;
`else
    exp_bo = 1'b0;
`endif
    run_vec(v, 1'b0);
    checks++; if (s_bv !== 7'b0000100 || s_bo[2] !== exp_bo) begin
      errors++; $display("FAIL negmax_bit: got bv=%b bo=%b expected 0000100 %b", s_bv, s_bo[2], exp_bo);
    end
  endtask

  task automatic test_decision();
    int   pk  [5];
    logic exp [5];
    pk = '{1000, 1000, -1000, -1000, 1000};
`ifdef DIFF_DECODE_EN
    exp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
    do_reset();
    bus_if.Threshold = 15'd500;
    repeat (3) run_std(1000, 1'b0);
    checks++; if (bus_if.Locked !== 1'b1) begin errors++; $display("FAIL dec_locked: got %b expected 1", bus_if.Locked); end
    for (int i = 0; i < 5; i++) begin
      run_std(pk[i], 1'b0);
      checks++; if (s_bv !== 7'b0001000 || s_bo[3] !== exp[i]) begin
        errors++; $display("FAIL dec_bit%0d: got bv=%b bo=%b expected 0001000 %b", i, s_bv, s_bo[3], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_lock();
    run_std(1000, 1'b1);
    checks++; if (s_bv !== 7'b0001000 || s_gbv !== 7'b0) begin
      errors++; $display("FAIL gap_bit: got bv=%b gapbv=%b expected 0001000 0000000", s_bv, s_gbv);
    end
    chip(-50);
    chip(50);
    chip(-50);
    reset         = 1'b1;
    bus_if.CorrIn = 15'd1000;
    @(negedge clk);
    checks++; if (bus_if.BitValid !== 1'b0 || bus_if.Locked !== 1'b0 || bus_if.BitOut !== 1'b0 ||
                  bus_if.PeakPhase !== 3'd0 || bus_if.PeakMag !== 15'd0) begin
      errors++; $display("FAIL midreset: got bv=%b lk=%b bo=%b ph=%0d mag=%0d expected all 0",
                         bus_if.BitValid, bus_if.Locked, bus_if.BitOut, bus_if.PeakPhase, bus_if.PeakMag);
    end
    reset            = 1'b0;
    bus_if.CorrValid = 1'b0;
    @(negedge clk);
    run_std(1000, 1'b1);
    run_std(1000, 1'b1);
    checks++; if (s_lk !== 7'b0 || s_bv !== 7'b0) begin
      errors++; $display("FAIL gap_verify: got lk=%b bv=%b expected 0000000 0000000", s_lk, s_bv);
    end
    run_std(1000, 1'b1);
    checks++; if (s_lk !== 7'b1111000) begin errors++; $display("FAIL gap_relock: got lk=%b expected 1111000", s_lk); end
    run_std(1000, 1'b1);
    checks++; if (s_bv !== 7'b0001000 || s_gbv !== 7'b0 || s_bo[3] !== 1'b1) begin
      errors++; $display("FAIL gap_relock_bit: got bv=%b gapbv=%b bo=%b expected 0001000 0000000 1", s_bv, s_gbv, s_bo[3]);
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset            = 1'b1;
    bus_if.CorrIn    = '0;
    bus_if.CorrValid = 1'b0;
    bus_if.Threshold = '0;
    @(negedge clk);
    test_reset();
    test_acquire();
    test_miss_drop();
    test_tie_negmax();
    test_decision();
    test_reset_mid_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
